// File: rtl/spi_counter_pkg.sv
// Shared frame geometry, command codes and FSM state type for the SPI counter receiver.
// Frame layout is [15:14] command, [13:0] counter payload, MSB first on the wire.
package spi_counter_pkg;
   localparam int DATA_W      = 14;
   localparam int FRAME_BITS  = 16;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = $clog2(FRAME_BITS + 2);

   localparam logic [1:0] CMD_COUNT = 2'b00;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      CHECK
   } spi_rx_state_t;
endpackage

// File: rtl/spi_counter_slave_rx_if.sv
// SPI pins plus the received-value path toward the display logic.
// The master modport is the SPI master/consumer side; slave is the receiver.
interface spi_counter_slave_rx_if;
   import spi_counter_pkg::*;

   logic              sclk;
   logic              mosi;
   logic              cs_n;
   logic              miso;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              frame_err;

   modport master (
      output sclk, mosi, cs_n,
      input  miso, rx_data, rx_valid, frame_err
   );

   modport slave (
      input  sclk, mosi, cs_n,
      output miso, rx_data, rx_valid, frame_err
   );
endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with registered rise/fall pulses.
// RESET_VAL lets idle-high inputs such as cs_n come out of reset without a false edge.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;
   logic                   rise_reg;
   logic                   fall_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg <= {SYNC_STAGES{RESET_VAL}};
         prev_reg <= RESET_VAL;
         rise_reg <= 1'b0;
         fall_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
         prev_reg <= sync_reg[SYNC_STAGES-1];
         rise_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
         fall_reg <= ~sync_reg[SYNC_STAGES-1] & prev_reg;
      end
   end

   assign sync_out = sync_reg[SYNC_STAGES-1];
   assign rise     = rise_reg;
   assign fall     = fall_reg;
endmodule

// File: rtl/spi_counter_slave_rx.sv
// SPI mode-0 slave receiving 16-bit counter frames in the clk domain.
// Accepted payloads are held on rx_data and echoed back on miso during the next frame.
module spi_counter_slave_rx
   import spi_counter_pkg::*;
#(
   parameter int SYNC_N = SYNC_STAGES
) (
   input  logic                  clk,
   input  logic                  reset,
   spi_counter_slave_rx_if.slave bus
);
   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic cs_rise, cs_fall, cs_level_unused;
   logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.SYNC_STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset(reset), .async_in(bus.sclk),
      .sync_out(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_N), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .async_in(bus.cs_n),
      .sync_out(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_N), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .async_in(bus.mosi),
      .sync_out(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   spi_rx_state_t           state_reg;
   logic [CNT_W-1:0]        bit_cnt_reg;
   logic [FRAME_BITS-1:0]   rx_shift_reg;
   logic [FRAME_BITS-1:0]   tx_shift_reg;
   logic [DATA_W-1:0]       rx_data_reg;
   logic                    rx_valid_reg;
   logic                    frame_err_reg;
   logic                    miso_reg;

   logic                    frame_ok;
   logic [DATA_W-1:0]       rx_data_next;
   logic [FRAME_BITS-1:0]   tx_load;

   assign frame_ok     = (bit_cnt_reg == CNT_W'(FRAME_BITS)) &&
                         (rx_shift_reg[FRAME_BITS-1 -: 2] == CMD_COUNT);
   assign rx_data_next = frame_ok ? rx_shift_reg[DATA_W-1:0] : rx_data_reg;
   // The echo word is built from the value that will be held after CHECK, so a
   // frame that starts straight out of CHECK already returns the fresh value.
   assign tx_load      = {{(FRAME_BITS-DATA_W){1'b0}},
                          (state_reg == CHECK) ? rx_data_next : rx_data_reg};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         bit_cnt_reg   <= '0;
         rx_shift_reg  <= '0;
         tx_shift_reg  <= '0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         miso_reg      <= 1'b0;
      end else begin
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (cs_fall) begin
                  state_reg    <= SHIFT;
                  bit_cnt_reg  <= '0;
                  rx_shift_reg <= '0;
                  tx_shift_reg <= tx_load;
                  miso_reg     <= tx_load[FRAME_BITS-1];
               end
            end
            SHIFT: begin
               // cs_n edges win over a coincident sclk edge
               if (cs_rise) begin
                  state_reg <= CHECK;
                  miso_reg  <= 1'b0;
               end else if (sclk_rise) begin
                  rx_shift_reg <= {rx_shift_reg[FRAME_BITS-2:0], mosi_sync};
                  if (bit_cnt_reg != CNT_W'(FRAME_BITS + 1))
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
               end else if (sclk_fall) begin
                  tx_shift_reg <= {tx_shift_reg[FRAME_BITS-2:0], 1'b0};
                  miso_reg     <= tx_shift_reg[FRAME_BITS-2];
               end
            end
            CHECK: begin
               rx_data_reg   <= rx_data_next;
               rx_valid_reg  <= frame_ok;
               frame_err_reg <= ~frame_ok;
               if (cs_fall) begin
                  state_reg    <= SHIFT;
                  bit_cnt_reg  <= '0;
                  rx_shift_reg <= '0;
                  tx_shift_reg <= tx_load;
                  miso_reg     <= tx_load[FRAME_BITS-1];
               end else begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.miso      = miso_reg;
   assign bus.rx_data   = rx_data_reg;
   assign bus.rx_valid  = rx_valid_reg;
   assign bus.frame_err = frame_err_reg;
endmodule

// File: tb/tb_spi_counter_slave_rx.sv
// Scoreboard bench: frame tasks queue the expected pulse, a monitor pops on each
// rx_valid/frame_err pulse; MISO echo and held values are checked inline.
module tb_spi_counter_slave_rx;
   import spi_counter_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   spi_counter_slave_rx_if bus ();

   spi_counter_slave_rx dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        is_err;
      logic [13:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        mon_e;
   int          checks   = 0;
   int          failures = 0;
   logic [13:0] model_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_frame();
      bus.cs_n = 1'b0;
      wait_clk(4);
   endtask

   // Bits go out MSB first; MISO is sampled just before each rising SCLK.
   task automatic shift_bits(input logic [31:0] word, input int n, output logic [15:0] miso_word);
      miso_word = '0;
      for (int i = n - 1; i >= 0; i--) begin
         bus.mosi = word[i];
         wait_clk(4);
         miso_word = {miso_word[14:0], bus.miso};
         bus.sclk = 1'b1;
         wait_clk(4);
         bus.sclk = 1'b0;
      end
   endtask

   task automatic end_frame();
      wait_clk(4);
      bus.cs_n = 1'b1;
      wait_clk(8);
   endtask

   task automatic send_frame(input logic [31:0] word, input int n);
      exp_t        e;
      logic [15:0] mw;
      logic [13:0] prev;
      prev = model_data;
      if (n == 16 && word[15:14] == 2'b00) begin
         e.is_err   = 1'b0;
         e.data     = word[13:0];
         model_data = word[13:0];
      end else begin
         e.is_err = 1'b1;
         e.data   = model_data;
      end
      exp_q.push_back(e);
      start_frame();
      shift_bits(word, n, mw);
      if (n == 16)
         check("miso_echo", {16'h0, mw}, {18'h0, prev});
      end_frame();
      check("miso_idle", {31'h0, bus.miso}, 32'h0);
   endtask

   always @(negedge clk) begin
      if (!reset && (bus.rx_valid || bus.frame_err)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse actual=valid:%b err:%b required=none t=%0t",
                     bus.rx_valid, bus.frame_err, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("pulse_kind", {30'h0, bus.frame_err, bus.rx_valid},
                  mon_e.is_err ? 32'h2 : 32'h1);
            check("rx_data_at_pulse", {18'h0, bus.rx_data}, {18'h0, mon_e.data});
         end
      end
   end

   initial begin
      logic [15:0] dummy;
      reset    = 1'b1;
      bus.sclk = 1'b0;
      bus.mosi = 1'b0;
      bus.cs_n = 1'b1;
      wait_clk(3);
      check("reset_rx_data",   {18'h0, bus.rx_data},   32'h0);
      check("reset_rx_valid",  {31'h0, bus.rx_valid},  32'h0);
      check("reset_frame_err", {31'h0, bus.frame_err}, 32'h0);
      check("reset_miso",      {31'h0, bus.miso},      32'h0);
      reset = 1'b0;
      wait_clk(4);

      // 1: plain accept
      send_frame(32'h0123, 16);
      check("t1_rx_data", {18'h0, bus.rx_data}, 32'h0123);
      // 3: short then long frame
      send_frame(32'h0123, 10);
      check("t3_short_hold", {18'h0, bus.rx_data}, 32'h0123);
      send_frame(32'h00123, 18);
      check("t3_long_hold", {18'h0, bus.rx_data}, 32'h0123);
      // 4: bad command
      send_frame(32'h8005, 16);
      check("t4_cmd_hold", {18'h0, bus.rx_data}, 32'h0123);
      // 2: all-ones payload, MISO echoes 0123
      send_frame(32'h3FFF, 16);
      check("t2_rx_data", {18'h0, bus.rx_data}, 32'h3FFF);

      // 5: reset after 8 bits of 16'h0055
      start_frame();
      shift_bits(32'h00, 8, dummy);
      bus.cs_n = 1'b1;
      reset    = 1'b1;
      #1;
      check("t5_rst_rx_data",   {18'h0, bus.rx_data},   32'h0);
      check("t5_rst_rx_valid",  {31'h0, bus.rx_valid},  32'h0);
      check("t5_rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
      check("t5_rst_miso",      {31'h0, bus.miso},      32'h0);
      wait_clk(3);
      reset      = 1'b0;
      model_data = '0;
      wait_clk(8);
      send_frame(32'h0055, 16);
      check("t5_rx_data", {18'h0, bus.rx_data}, 32'h0055);

      // 6: back-to-back frames with one SCLK period of cs_n high
      send_frame(32'h0001, 16);
      send_frame(32'h0002, 16);
      wait_clk(20);
      check("t6_rx_data", {18'h0, bus.rx_data}, 32'h0002);
      check("queue_drained", exp_q.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
